// File: rtl/acb_pkg.sv
// acb_pkg: shared definitions for the acb arbiter slice.
//   ACB_WIDTH      default field element width (GF(2^163))
//   acb_state_e    arbiter FSM state encoding
//   MODE_*         request mode encoding seen on req_mode / acb_configuration
package acb_pkg;

  localparam int ACB_WIDTH = 163;

  // Mode bit as carried on req_mode and driven to the core's configuration.
  localparam logic MODE_SQR_PROD = 1'b0;  // (A*B)^2
  localparam logic MODE_PROD     = 1'b1;  // A*B

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } acb_state_e;

endpackage

// File: rtl/acb_rr_arb2.sv
// acb_rr_arb2: combinational two-way round-robin grant.
//   req_valid [1:0]  request bits, bit i = requester i
//   ptr              requester favoured when both are valid
//   en               grant enable; no grant when low
//   gnt [1:0]        one-hot grant (or zero)
module acb_rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/acb_arbiter.sv
// acb_arbiter: two-port round-robin arbiter / sequencer in front of the shared
// GF(2^163) multiply/square core.
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]     per-requester request handshake
//   req_mode [1:0]                per-requester mode (1 = A*B, 0 = (A*B)^2)
//   req_a0/req_b0, req_a1/req_b1  operands of requester 0 / 1
//   rsp_valid/rsp_ready [1:0]     per-requester response handshake
//   rsp_c, rsp_err                shared response data and timeout flag
//   acb_enable, acb_configuration core controls
//   acb_a, acb_b                  core operands
//   acb_c, acb_done               core result and completion
module acb_arbiter
  import acb_pkg::*;
#(
  parameter int WIDTH   = ACB_WIDTH,
  parameter int TIMEOUT = 511
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic             acb_enable,
  output logic             acb_configuration,
  output logic [WIDTH-1:0] acb_a,
  output logic [WIDTH-1:0] acb_b,
  input  logic [WIDTH-1:0] acb_c,
  input  logic             acb_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  acb_state_e       state_reg, state_next;
  logic             ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             owner_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic             err_reg;

  logic [1:0]       gnt;
  logic             grant_en;
  logic             win;
  logic             timeout_hit;

  // A done still high from the previous operation must not be mistaken for
  // the completion of a new one, so it holds off the grant. rst_n is folded
  // in so req_ready stays low for the whole reset pulse.
  assign grant_en    = rst_n && (state_reg == ST_IDLE) && !acb_done;
  assign win         = gnt[1];
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  acb_rr_arb2 u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .en        (grant_en),
    .gnt       (gnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (|gnt)                      state_next = ST_BUSY;
      ST_BUSY: if (acb_done || timeout_hit)   state_next = ST_RESP;
      ST_RESP: if (rsp_ready[owner_reg])      state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready         = 2'b00;
    rsp_valid         = 2'b00;
    acb_enable        = 1'b0;
    acb_configuration = 1'b0;
    acb_a             = '0;
    acb_b             = '0;
    case (state_reg)
      ST_IDLE: req_ready = gnt;
      ST_BUSY: begin
        acb_enable        = 1'b1;
        acb_configuration = mode_reg;
        acb_a             = a_reg;
        acb_b             = b_reg;
      end
      ST_RESP: rsp_valid[owner_reg] = 1'b1;
      default: ;
    endcase
  end

  assign rsp_c   = c_reg;
  assign rsp_err = err_reg;

  // Operand latch, round-robin pointer, timeout counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= 1'b0;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      mode_reg  <= MODE_SQR_PROD;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|gnt) begin
            owner_reg <= win;
            mode_reg  <= req_mode[win];
            a_reg     <= win ? req_a1 : req_a0;
            b_reg     <= win ? req_b1 : req_b0;
            cnt_reg   <= '0;
            // Pointer only moves on contention: the loser goes first next time.
            if (&req_valid) ptr_reg <= ~win;
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          // done has priority over a timeout landing in the same cycle
          if (acb_done) begin
            c_reg   <= acb_c;
            err_reg <= 1'b0;
          end else if (timeout_hit) begin
            c_reg   <= '0;
            err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acb_arbiter.sv
`timescale 1ns/1ps
// tb_acb_arbiter: self-checking bench for acb_arbiter. The bench plays both
// requesters and the arithmetic core; expected winners come from a small
// round-robin model (pending set + pointer integer).
module tb_acb_arbiter;

  localparam int W  = 163;
  localparam int TO = 511;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   req_mode = 2'b00;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b00;
  logic [W-1:0] rsp_c;
  logic         rsp_err;
  logic         acb_enable, acb_configuration;
  logic [W-1:0] acb_a, acb_b;
  logic [W-1:0] acb_c = '0;
  logic         acb_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;   // model of the round-robin pointer

  acb_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_mode          (req_mode),
    .req_a0            (req_a0),
    .req_b0            (req_b0),
    .req_a1            (req_a1),
    .req_b1            (req_b1),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_c             (rsp_c),
    .rsp_err           (rsp_err),
    .acb_enable        (acb_enable),
    .acb_configuration (acb_configuration),
    .acb_a             (acb_a),
    .acb_b             (acb_b),
    .acb_c             (acb_c),
    .acb_done          (acb_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic set_req(input int p, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    req_mode[p] = m;
    if (p == 0) begin req_a0 = a; req_b0 = b; end
    else        begin req_a1 = a; req_b1 = b; end
    req_valid[p] = 1'b1;
  endtask

  // Wait for a grant, compare it with the model's winner, then check the core
  // is driven with the winner's operands from the cycle after acceptance.
  task automatic accept(output int w, output logic m, output logic [W-1:0] a, output logic [W-1:0] b);
    int n = 0;
    int exp_w;
    #1;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    exp_w = (req_valid == 2'b11) ? ptr_m : (req_valid[1] ? 1 : 0);
    w = exp_w;
    m = req_mode[exp_w];
    a = exp_w ? req_a1 : req_a0;
    b = exp_w ? req_b1 : req_b0;
    chk("req_ready_grant", W'(req_ready), W'(2'b01 << exp_w));
    if (req_valid == 2'b11) ptr_m = 1 - exp_w;
    @(posedge clk);
    @(negedge clk);
    req_valid[exp_w] = 1'b0;
    #1;
    chk("busy_enable", W'(acb_enable), W'(1'b1));
    chk("busy_cfg", W'(acb_configuration), W'(m));
    chk("busy_a", acb_a, a);
    chk("busy_b", acb_b, b);
    chk("busy_no_ready", W'(req_ready), W'(2'b00));
  endtask

  // Act as the core (done after lat cycles, or never when lat <= 0), then
  // check the response and hand it back after 'hold' cycles of non-owner ready.
  task automatic complete(input int w, input logic m, input int lat, input logic [W-1:0] c, input int hold);
    logic ok = 1'b1;
    int   n  = 0;
    if (lat > 0) begin
      for (int k = 1; k < lat; k++) begin
        @(negedge clk);
        if (acb_enable !== 1'b1 || acb_configuration !== m || rsp_valid !== 2'b00) ok = 1'b0;
      end
      chk("busy_stable", W'(ok), W'(1'b1));
      acb_done = 1'b1;
      acb_c    = c;
      @(negedge clk);
      acb_done = 1'b0;
      acb_c    = rnd_fe();
      #1;
      chk("rsp_valid", W'(rsp_valid), W'(2'b01 << w));
      chk("rsp_c", rsp_c, c);
      chk("rsp_err", W'(rsp_err), W'(1'b0));
      chk("resp_enable_low", W'(acb_enable), W'(1'b0));
    end else begin
      while (rsp_valid == 2'b00 && n < TO + 50) begin
        @(negedge clk); n++;
      end
      chk("timeout_latency", W'(n), W'(TO));
      chk("timeout_valid", W'(rsp_valid), W'(2'b01 << w));
      chk("timeout_err", W'(rsp_err), W'(1'b1));
      chk("timeout_c", rsp_c, W'(0));
      c = '0;
    end
    for (int k = 0; k < hold; k++) begin
      rsp_ready[1-w] = 1'b1;
      @(negedge clk); #1;
      chk("rsp_hold_valid", W'(rsp_valid), W'(2'b01 << w));
      chk("rsp_hold_c", rsp_c, c);
    end
    rsp_ready    = 2'b00;
    rsp_ready[w] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("rsp_released", W'(rsp_valid), W'(2'b00));
    $display("op port=%0d mode=%0d lat=%0d c=%0h", w, m, lat, c);
  endtask

  typedef struct {
    int           port;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] c;
    int           hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int           w;
    logic         m;
    logic [W-1:0] a, b;
    int           exp_order[3];

    vecs[0] = '{port:0, mode:1'b1, a:W'(2), b:W'(3), lat:163, c:W'(6), hold:0};
    vecs[1] = '{port:1, mode:1'b0, a:W'(5), b:W'(7), lat:40, c:W'(64'h1234_5678_9abc_def0), hold:2};
    vecs[2] = '{port:0, mode:1'b0, a:'1, b:W'(1), lat:1, c:'1, hold:1};
    vecs[3] = '{port:1, mode:1'b1, a:rnd_fe(), b:rnd_fe(), lat:200, c:rnd_fe(), hold:0};
    vecs[4] = '{port:0, mode:1'b1, a:rnd_fe(), b:rnd_fe(), lat:0, c:W'(0), hold:1};
    vecs[5] = '{port:1, mode:1'b0, a:rnd_fe(), b:rnd_fe(), lat:10, c:rnd_fe(), hold:0};
    exp_order = '{0, 1, 0};

    // Reset state, with both requesters already asking
    set_req(0, 1'b1, W'(11), W'(12));
    set_req(1, 1'b0, W'(21), W'(22));
    #7;
    chk("rst_req_ready", W'(req_ready), W'(2'b00));
    chk("rst_rsp_valid", W'(rsp_valid), W'(2'b00));
    chk("rst_rsp_c", rsp_c, W'(0));
    chk("rst_rsp_err", W'(rsp_err), W'(1'b0));
    chk("rst_enable", W'(acb_enable), W'(1'b0));
    chk("rst_cfg", W'(acb_configuration), W'(1'b0));
    chk("rst_acb_a", acb_a, W'(0));
    chk("rst_acb_b", acb_b, W'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: 0, 1, 0
    for (int i = 0; i < 3; i++) begin
      accept(w, m, a, b);
      chk("both_order", W'(w), W'(exp_order[i]));
      complete(w, m, 5 + i, W'(100 + i), 0);
      set_req(w, ~m, a + W'(1), b);
    end

    // Reset during BUSY with ptr = 1: port 1 alone wins, pointer stays at 1
    req_valid[0] = 1'b0;
    accept(w, m, a, b);
    repeat (20) @(negedge clk);
    #2;
    set_req(0, 1'b1, W'(31), W'(32));
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", W'(acb_enable), W'(1'b0));
    chk("midrst_rsp_valid", W'(rsp_valid), W'(2'b00));
    chk("midrst_req_ready", W'(req_ready), W'(2'b00));
    set_req(1, 1'b0, W'(41), W'(42));
    ptr_m = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    accept(w, m, a, b);
    chk("post_reset_ptr", W'(w), W'(0));
    complete(w, m, 12, W'(77), 0);
    accept(w, m, a, b);
    complete(w, m, 3, W'(78), 0);

    // Table of single-requester operations (incl. timeout and recovery)
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].port, vecs[i].mode, vecs[i].a, vecs[i].b);
      accept(w, m, a, b);
      chk("vec_port", W'(w), W'(vecs[i].port));
      complete(w, m, vecs[i].lat, vecs[i].c, vecs[i].hold);
    end

    // Stale done in IDLE: no response, and no grant while it stays high
    acb_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("idle_done_no_rsp", W'(rsp_valid), W'(2'b00));
    end
    set_req(1, 1'b1, W'(9), W'(10));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stale_done_no_grant", W'(req_ready), W'(2'b00));
      chk("stale_done_no_enable", W'(acb_enable), W'(1'b0));
    end
    @(negedge clk);
    acb_done = 1'b0;
    accept(w, m, a, b);
    complete(w, m, 7, W'(90), 0);

    // Randomised traffic against the round-robin model
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req_valid[p] && ($urandom % 3 != 0))
          set_req(p, 1'($urandom), rnd_fe(), rnd_fe());
      if (req_valid == 2'b00)
        set_req(int'($urandom_range(0, 1)), 1'($urandom), rnd_fe(), rnd_fe());
      accept(w, m, a, b);
      complete(w, m, int'($urandom_range(1, 30)), rnd_fe(), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acb_arbiter.md
# acb_arbiter

Two-port round-robin arbiter and sequencer for the shared GF(2^163) arithmetic core (`acb`: interleaved multiplier plus squarer). Each requester hands over one operation at a time over a valid/ready handshake: operands, plus a mode selecting either the product or the squared product. The block latches the winner's operands and drives the core's `enable` and `configuration` inputs. It captures the result on `done`, or flags a timeout, and returns the result on the owning requester's response channel. It sits between the point-arithmetic sequencers and the single `acb` instance.

## Interface
- `WIDTH`, 163: field element width.
- `TIMEOUT`, 511: maximum BUSY cycles before an error response; must be ≥ 200.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 2: per-requester request valid; bit i belongs to requester i.
- `req_ready` output 2: per-requester request accept.
- `req_mode` input 2: per-requester mode. 1 = product A·B; 0 = (A·B)².
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input WIDTH: operands for requester 0 and requester 1.
- `rsp_valid` output 2: per-requester response valid.
- `rsp_ready` input 2: per-requester response accept.
- `rsp_c` output WIDTH: response data, shared by both requesters and qualified by `rsp_valid`.
- `rsp_err` output 1: timeout flag, qualified by `rsp_valid`.
- `acb_enable`, `acb_configuration` output 1: core controls.
- `acb_a`, `acb_b` output WIDTH: core operands.
- `acb_c` input WIDTH: core result.
- `acb_done` input 1: core completion.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: one operation in flight on the core.
  - RESP: holding the response for the owner.
- IDLE grant rule:
  - A grant needs at least one `req_valid` bit set and `acb_done` = 0. A stale `acb_done` from the previous operation blocks the grant.
  - Only one requester valid: it wins.
  - Both valid: the requester named by `ptr` wins, then `ptr` ← loser.
  - `req_ready[win]` = 1 combinationally in that cycle.
  - On that edge: latch operands, mode and owner id, clear `cnt`, go to BUSY.
- BUSY:
  - `acb_enable` = 1, `acb_configuration` = mode_q, `acb_a`/`acb_b` = latched operands.
  - `cnt` increments every BUSY cycle.
  - `acb_done` = 1: `rsp_c` ← `acb_c`, `rsp_err` ← 0, go to RESP.
  - `cnt` = TIMEOUT − 1 with no done: `rsp_c` ← 0, `rsp_err` ← 1, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - `acb_enable` = 0.
  - `rsp_valid[owner]` = 1, held stable until `rsp_ready[owner]`; then go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `acb_done` is ignored outside BUSY.
- `req_ready` = 0 outside IDLE. Requests arriving in BUSY or RESP wait; arbitration is not queued.
- Width rule: no arithmetic on operands. `cnt` width is $clog2(TIMEOUT+1).

## Timing
- Request accepted on edge T; `acb_enable` high from T+1.
- `acb_done` sampled high at edge D; `acb_enable` low and `rsp_valid` high from D+1.
- Minimum gap between accepts is two cycles after the response handshake (RESP→IDLE, then grant).
- Reset (`rst_n` low, asynchronous), outputs:
  - State IDLE, `ptr` = 0, `cnt` = 0.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_c` = 0, `rsp_err` = 0.
  - `acb_enable` = 0, `acb_configuration` = 0, `acb_a` = 0, `acb_b` = 0.
- Reset mid-operation: all of the above apply immediately and the in-flight result is discarded. Requesters must re-issue.

## Structure
- Package `acb_pkg`:
  - State encoding (IDLE = 0, BUSY = 1, RESP = 2).
  - `WIDTH` default.
  - Mode constants `MODE_SQR_PROD` = 0, `MODE_PROD` = 1.
- Sub-module `acb_rr_arb2`: combinational two-way round-robin grant from `req_valid`, `ptr` and an enable. Outputs one-hot grant.
- FSM, operand/response registers and timeout counter stay in `acb_arbiter`.

## Test plan
- Single request on port 0 (mode 1, A = 2, B = 3), core model asserts done 163 cycles later with C = 6:
  - `rsp_valid` = 2'b01, `rsp_c` = 6, `rsp_err` = 0 at D+1.
  - `acb_configuration` = 1 throughout BUSY.
- Both ports valid from reset:
  - Port 0 granted first, then port 1, then port 0.
  - `req_ready` never has both bits high.
  - Each response goes to the correct bit.
- Mode 0 request: `acb_configuration` = 0 during BUSY; response carries the core's `acb_c` unchanged.
- Core never asserts done, TIMEOUT = 511:
  - `rsp_valid` at BUSY cycle 512 with `rsp_err` = 1, `rsp_c` = 0.
  - Next request is served normally.
- `acb_done` held high after RESP: no grant until it drops; `acb_done` pulses in IDLE cause no response.
- `rst_n` pulsed low mid-BUSY:
  - `acb_enable` drops asynchronously, no `rsp_valid`.
  - `ptr` = 0, and a fresh request completes.
